alu_result_fifo: RTL
====================

Name: alu_result_fifo

Overview:
Downstream result stage for the 8-bit ALU top. It captures each ALU result (Y, Cout) and its opcode, computes status flags, and buffers entries in a DEPTH-entry first-word-fall-through FIFO with a valid/ready handshake towards the consumer. It also keeps statistics counters for accepted results and producer stall cycles.

Parameters:
DATA_W, 8, result width (matches ALU Y)
OP_W, 3, opcode width (matches ALU op)
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of statistics counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer has a result on in_y/in_cout/in_op
in_ready  output  1  FIFO can accept this cycle
in_y  input  DATA_W  ALU result Y
in_cout  input  1  ALU carry out
in_op  input  OP_W  opcode that produced the result
out_valid  output  1  head entry valid
out_ready  input  1  consumer takes head entry
out_y  output  DATA_W  head result
out_op  output  OP_W  head opcode
out_flags  output  4  head flags {C,Z,N,P}
count  output  $clog2(DEPTH+1)  current occupancy
result_cnt  output  CNT_W  accepted pushes, wrapping
stall_cnt  output  CNT_W  producer stall cycles, saturating
clr_stats  input  1  synchronous clear of result_cnt and stall_cnt

Behaviour:
- Single clock domain clk. rst is synchronous and active-high and is sampled only on the rising edge.
- On rst:
  - write and read pointers = 0, count = 0
  - result_cnt = 0, stall_cnt = 0
  - out_valid = 0; out_y, out_op and out_flags read 0
  - Storage array is not reset.
- rst mid-operation discards all entries. rst has priority over every other input in that cycle.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It is registered-state-derived only, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_y, out_op and out_flags are driven from the head entry when out_valid = 1. They are forced to 0 when out_valid = 0.
- Flags are computed at push time and stored with the entry:
  - C = in_cout
  - Z = (in_y == 0)
  - N = in_y[DATA_W-1]
  - P = XOR-reduction of in_y (1 = odd number of ones)
- Latency: a push on edge k makes the entry visible at out_* with out_valid = 1 immediately after edge k if the FIFO was empty (1-cycle latency). There is no bypass in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push && pop: count unchanged; both pointers advance and order is preserved.
- Full (count = DEPTH): in_ready = 0, so no push occurs. A pop in that cycle frees a slot for the next cycle only.
- Empty: pop is impossible because out_valid = 0. out_ready is ignored.
- Producer must hold in_* stable while in_valid && !in_ready. Consumer may drop out_ready at any time.
- result_cnt:
  - +1 on every push, wrapping at 2^CNT_W
  - clr_stats sets it to 0; clr_stats wins over a simultaneous push.
- stall_cnt:
  - +1 on each cycle with in_valid && !in_ready
  - saturates at 2^CNT_W-1
  - clr_stats sets it to 0 and wins over a simultaneous stall.
- clr_stats does not affect FIFO contents, pointers or count.

Test Plan:
- Reset, then push in_y=0x80, in_cout=0, in_op=3 with out_ready=0. Required next cycle: out_valid=1, out_y=0x80, out_op=3, out_flags={C0,Z0,N1,P1}=0b0011, count=1, result_cnt=1.
- Push in_y=0x00, in_cout=1. Required at head: flags {C1,Z1,N0,P0}=0b1100.
- Hold out_ready=0 and push 4 entries 0x11,0x22,0x33,0x44, then keep in_valid=1 for 5 more cycles. Required: count=4, in_ready=0, stall_cnt=5, result_cnt=4. Then out_ready=1 pops 0x11,0x22,0x33,0x44 in order.
- At count=2, drive push and pop in the same cycle for 10 consecutive cycles with sequence 0x01..0x0A. Required: count stays 2, and popped order matches pushed order across pointer wrap.
- With count=3 and result_cnt=3, assert rst for one cycle together with in_valid=1 and out_ready=1. Required after the edge: count=0, out_valid=0, out_y=0, result_cnt=0, stall_cnt=0, and no push is recorded.
- Hold the full stall for 300 cycles. Required: stall_cnt saturates at 255. Then clr_stats=1 for one cycle: stall_cnt=0 and result_cnt=0, with count and contents unchanged.

Source files
------------

// File: rtl/alu_result_fifo_if.sv
// rtl/alu_result_fifo_if.sv - ALU result producer and consumer handshake bundle
interface alu_result_fifo_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_y;
   logic              in_cout;
   logic [OP_W-1:0]   in_op;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_y;
   logic [OP_W-1:0]   out_op;
   logic [3:0]        out_flags;

   modport master (
      output in_valid, in_y, in_cout, in_op, out_ready,
      input  in_ready, out_valid, out_y, out_op, out_flags
   );

   modport slave (
      input  in_valid, in_y, in_cout, in_op, out_ready,
      output in_ready, out_valid, out_y, out_op, out_flags
   );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - first-word-fall-through FIFO of ALU results with flags and statistics
module alu_result_fifo #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   alu_result_fifo_if.slave           bus,
   input  logic                       clr_stats,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [CNT_W-1:0]           result_cnt,
   output logic [CNT_W-1:0]           stall_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
   localparam logic [CW-1:0]    CNT_INC = CW'(1);
   localparam logic [PW-1:0]    PTR_INC = PW'(1);
   localparam logic [CNT_W-1:0] ST_INC  = CNT_W'(1);

   logic [DATA_W-1:0] mem_y     [DEPTH];
   logic [OP_W-1:0]   mem_op    [DEPTH];
   logic [3:0]        mem_flags [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          stall;
   logic [3:0]    in_flags;

   assign bus.in_ready  = (count != FULL);
   assign bus.out_valid = (count != '0);
   assign push  = bus.in_valid && bus.in_ready;
   assign pop   = bus.out_valid && bus.out_ready;
   assign stall = bus.in_valid && !bus.in_ready;

   // {C, Z, N, P}; P is 1 for an odd number of ones in Y
   assign in_flags = {bus.in_cout, (bus.in_y == '0), bus.in_y[DATA_W-1], ^bus.in_y};

   assign bus.out_y     = bus.out_valid ? mem_y[rd_ptr]     : '0;
   assign bus.out_op    = bus.out_valid ? mem_op[rd_ptr]    : '0;
   assign bus.out_flags = bus.out_valid ? mem_flags[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_y[wr_ptr]     <= bus.in_y;
         mem_op[wr_ptr]    <= bus.in_op;
         mem_flags[wr_ptr] <= in_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_INC;
         if (pop)  rd_ptr <= rd_ptr + PTR_INC;
         case ({push, pop})
            2'b10:   count <= count + CNT_INC;
            2'b01:   count <= count - CNT_INC;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         result_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (push) result_cnt <= result_cnt + ST_INC;
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + ST_INC;
      end
   end
endmodule
